// File: rtl/adc_fe_pkg.sv
// adc_fe_pkg: config bit positions, pipeline latency and saturation helper shared by the ADC front end
package adc_fe_pkg;
  localparam int CFG_OFFSET_BIN = 0;
  localparam int CFG_DC_EN      = 1;
  localparam int CFG_DC_FREEZE  = 2;
  localparam int CFG_DC_CLR     = 3;
  localparam int CFG_HOLD_LSB   = 16;
  localparam int CFG_HOLD_MSB   = 31;
  localparam int ADC_FE_LAT     = 3;
  function automatic logic signed [31:0] saturate(input logic signed [31:0] v, input int bits);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (bits - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (bits - 1));
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
endpackage

// File: rtl/adc_dc_block.sv
// adc_dc_block: leaky-integrator DC removal with output saturation; forms the S2 register stage
module adc_dc_block
  import adc_fe_pkg::*;
#(
  parameter int ADC_BITS = 14,
  parameter int DC_SHIFT = 12
) (
  input  logic                       adc_clk,
  input  logic                       adc_rst_n,
  input  logic signed [ADC_BITS-1:0] x,
  input  logic                       dc_en,
  input  logic                       dc_freeze,
  input  logic                       dc_clr,
  output logic signed [ADC_BITS-1:0] y,
  output logic                       sat
);
  localparam int AW = ADC_BITS + DC_SHIFT;
  logic signed [AW-1:0]       acc;
  logic signed [ADC_BITS-1:0] est;
  logic signed [ADC_BITS-1:0] y_sat;
  logic signed [ADC_BITS:0]   diff;
  logic signed [31:0]         clamped;
  always_comb begin
    est     = ADC_BITS'(acc >>> DC_SHIFT);
    diff    = (ADC_BITS+1)'(x) - (ADC_BITS+1)'(est);
    clamped = saturate(32'(diff), ADC_BITS);
    y_sat   = ADC_BITS'(clamped);
  end
  // The integrator accumulates the unsaturated difference so clipping does not bias the estimate.
  always_ff @(posedge adc_clk or negedge adc_rst_n)
    if (!adc_rst_n) begin
      acc <= '0;
      y   <= '0;
      sat <= 1'b0;
    end else begin
      y   <= dc_en ? y_sat : x;
      sat <= dc_en && (clamped != 32'(diff));
      acc <= dc_clr ? '0 : (dc_en && !dc_freeze) ? acc + AW'(diff) : acc;
    end
endmodule

// File: rtl/adc_front_end.sv
// adc_front_end: ADC capture, format conversion, optional DC removal, peak and clip indicators.
// Define ADC_DC_BLOCK_EN to build the DC block; otherwise S2 is a plain register.
module adc_front_end
  import adc_fe_pkg::*;
#(
  parameter int ADC_BITS       = 14,
  parameter int DC_SHIFT       = 12,
  parameter int CLIP_HOLD_BITS = 16
) (
  input  logic                       adc_clk,
  input  logic                       adc_rst_n,
  input  logic [ADC_BITS-1:0]        adc_raw_in,
  input  logic                       adc_or_in,
  input  logic                       cfg_wr_A,
  input  logic [31:0]                cfg_data_A,
  input  logic                       peak_clr_A,
  output logic signed [ADC_BITS-1:0] adc_data,
  output logic                       adc_ovfl,
  output logic [ADC_BITS-2:0]        adc_peak,
  output logic                       clip_hold
);
  logic                               offset_bin;
  logic [CFG_HOLD_MSB-CFG_HOLD_LSB:0] hold_len;
  logic signed [ADC_BITS-1:0]         s1_x;
  logic signed [ADC_BITS-1:0]         s2_y;
  logic                               s1_or;
  logic                               s2_or;
  logic                               s2_sat;
  logic [CLIP_HOLD_BITS-1:0]          clip_cnt;
  logic [ADC_BITS-1:0]                neg;
  logic [ADC_BITS-2:0]                mag;
  // Negating the most-negative code wraps back to itself; clamp that case to full scale.
  always_comb begin
    neg = -adc_data;
    mag = adc_data[ADC_BITS-1] ? (neg[ADC_BITS-1] ? '1 : neg[ADC_BITS-2:0]) : adc_data[ADC_BITS-2:0];
  end
  always_ff @(posedge adc_clk or negedge adc_rst_n)
    if (!adc_rst_n) begin
      offset_bin <= 1'b0;
      hold_len   <= '0;
      s1_x       <= '0;
      s1_or      <= 1'b0;
      s2_or      <= 1'b0;
      adc_data   <= '0;
      adc_ovfl   <= 1'b0;
      adc_peak   <= '0;
      clip_cnt   <= '0;
      clip_hold  <= 1'b0;
    end else begin
      if (cfg_wr_A) begin
        offset_bin <= cfg_data_A[CFG_OFFSET_BIN];
        hold_len   <= cfg_data_A[CFG_HOLD_MSB:CFG_HOLD_LSB];
      end
      s1_x      <= adc_raw_in ^ {offset_bin, {(ADC_BITS-1){1'b0}}};
      s1_or     <= adc_or_in;
      s2_or     <= s1_or;
      adc_data  <= s2_y;
      adc_ovfl  <= s2_or | s2_sat;
      adc_peak  <= (peak_clr_A || mag > adc_peak) ? mag : adc_peak;
      clip_cnt  <= adc_ovfl ? CLIP_HOLD_BITS'(hold_len) : clip_cnt != '0 ? clip_cnt - CLIP_HOLD_BITS'(1) : clip_cnt;
      clip_hold <= adc_ovfl || clip_cnt != '0;
    end
`ifdef ADC_DC_BLOCK_EN
  logic dc_en;
  logic dc_freeze;
  logic unused_cfg;
  assign unused_cfg = ^cfg_data_A[CFG_HOLD_LSB-1:CFG_DC_CLR+1];
  always_ff @(posedge adc_clk or negedge adc_rst_n)
    if (!adc_rst_n) begin
      dc_en     <= 1'b0;
      dc_freeze <= 1'b0;
    end else if (cfg_wr_A) begin
      dc_en     <= cfg_data_A[CFG_DC_EN];
      dc_freeze <= cfg_data_A[CFG_DC_FREEZE];
    end
  adc_dc_block #(.ADC_BITS(ADC_BITS), .DC_SHIFT(DC_SHIFT)) u_dc_block (
    .adc_clk,
    .adc_rst_n,
    .x(s1_x),
    .dc_en,
    .dc_freeze,
    .dc_clr(cfg_wr_A & cfg_data_A[CFG_DC_CLR]),
    .y(s2_y),
    .sat(s2_sat)
  );
`else
  localparam int unused_dc_shift = DC_SHIFT;
  logic unused_cfg;
  assign unused_cfg = ^cfg_data_A[CFG_HOLD_LSB-1:CFG_OFFSET_BIN+1];
  assign s2_sat = 1'b0;
  always_ff @(posedge adc_clk or negedge adc_rst_n)
    if (!adc_rst_n) s2_y <= '0;
    else s2_y <= s1_x;
`endif
endmodule

// File: tb/tb_adc_front_end.sv
// tb_adc_front_end: vector tables plus hand-written multi-cycle sequences for adc_front_end
module tb_adc_front_end;
  import adc_fe_pkg::*;
  localparam int D = ADC_FE_LAT - 1;
  typedef struct {
    logic [13:0] raw;
    logic        ovr;
    logic [13:0] data;
    logic        ovfl;
  } vec_t;
  logic        adc_clk = 1'b0;
  logic        adc_rst_n = 1'b0;
  logic [13:0] adc_raw_in = 14'h1FFF;
  logic        adc_or_in = 1'b1;
  logic        cfg_wr_A = 1'b0;
  logic [31:0] cfg_data_A = '0;
  logic        peak_clr_A = 1'b0;
  logic [13:0] adc_data;
  logic        adc_ovfl;
  logic [12:0] adc_peak;
  logic        clip_hold;
  int          checks = 0;
  int          errors = 0;
  vec_t        vecs[9];

  adc_front_end dut (
    .adc_clk(adc_clk),
    .adc_rst_n(adc_rst_n),
    .adc_raw_in(adc_raw_in),
    .adc_or_in(adc_or_in),
    .cfg_wr_A(cfg_wr_A),
    .cfg_data_A(cfg_data_A),
    .peak_clr_A(peak_clr_A),
    .adc_data(adc_data),
    .adc_ovfl(adc_ovfl),
    .adc_peak(adc_peak),
    .clip_hold(clip_hold)
  );

  always #5 adc_clk = ~adc_clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge adc_clk);
    #1;
  endtask

  task automatic feed(input logic [13:0] r);
    adc_raw_in = r;
    step();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic cfg_write(input logic [31:0] d);
    cfg_wr_A = 1'b1;
    cfg_data_A = d;
    step();
    cfg_wr_A = 1'b0;
    cfg_data_A = '0;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi + D; i++) begin
      adc_raw_in = i <= hi ? vecs[i].raw : 14'h0;
      adc_or_in = i <= hi ? vecs[i].ovr : 1'b0;
      step();
      if (i >= lo + D) begin
        chk($sformatf("vec%0d_data", i - D), 32'(adc_data), 32'(vecs[i-D].data));
        chk($sformatf("vec%0d_ovfl", i - D), 32'(adc_ovfl), 32'(vecs[i-D].ovfl));
      end
    end
    adc_or_in = 1'b0;
  endtask

  task automatic clip_run(input string name, input logic [15:0] h, input logic [15:0] or_pat,
                          input logic [15:0] exp_ovfl, input logic [15:0] exp_clip);
    logic [15:0] ov;
    logic [15:0] cl;
    ov = '0;
    cl = '0;
    cfg_write({h, 16'h0});
    for (int i = 0; i < 16; i++) begin
      adc_or_in = or_pat[i];
      feed(14'h0);
      ov[i] = adc_ovfl;
      cl[i] = clip_hold;
    end
    adc_or_in = 1'b0;
    chk({name, "_ovfl"}, 32'(ov), 32'(exp_ovfl));
    chk({name, "_clip"}, 32'(cl), 32'(exp_clip));
  endtask

  initial begin
    int v0;
    vecs[0] = '{14'h1FFF, 1'b0, 14'h1FFF, 1'b0};
    vecs[1] = '{14'h2000, 1'b1, 14'h2000, 1'b1};
    vecs[2] = '{14'h0064, 1'b0, 14'h0064, 1'b0};
    vecs[3] = '{14'h3FFF, 1'b1, 14'h3FFF, 1'b1};
    vecs[4] = '{14'h2000, 1'b0, 14'h0000, 1'b0};
    vecs[5] = '{14'h3FFF, 1'b0, 14'h1FFF, 1'b0};
    vecs[6] = '{14'h0000, 1'b1, 14'h2000, 1'b1};
    vecs[7] = '{14'h1FFF, 1'b0, 14'h3FFF, 1'b0};
    vecs[8] = '{14'h2064, 1'b0, 14'h0064, 1'b0};

    repeat (3) step();
    chk("rst_data", 32'(adc_data), 0);
    chk("rst_ovfl", 32'(adc_ovfl), 0);
    chk("rst_peak", 32'(adc_peak), 0);
    chk("rst_clip", 32'(clip_hold), 0);
    adc_raw_in = 14'h0;
    adc_or_in = 1'b0;
    adc_rst_n = 1'b1;

    run_vecs(0, 3);

    // Sample presented with the write keeps the old format; the next one is converted.
    adc_raw_in = 14'h2000;
    cfg_write(32'h1);
    feed(14'h2000);
    feed(14'h0);
    chk("cfg_edge_old", 32'(adc_data), 32'h2000);
    feed(14'h0);
    chk("cfg_edge_new", 32'(adc_data), 32'h0000);
    run_vecs(4, 8);
    cfg_write(32'h0);

    clip_run("h5_single", 16'd5, 16'h0001, 16'h0004, 16'h01F8);
    clip_run("h5_reload", 16'd5, 16'h0005, 16'h0014, 16'h07F8);
    clip_run("h0_single", 16'd0, 16'h0001, 16'h0004, 16'h0008);

    repeat (3) feed(14'h0);
    peak_clr_A = 1'b1;
    feed(14'h2000);
    peak_clr_A = 1'b0;
    chk("peak_clr_zero", 32'(adc_peak), 0);
    feed(14'd100);
    feed(14'd50);
    chk("data_min", 32'(adc_data), 32'h2000);
    feed(14'd50);
    chk("peak_min_sat", 32'(adc_peak), 8191);
    peak_clr_A = 1'b1;
    feed(14'd300);
    peak_clr_A = 1'b0;
    chk("peak_clr_live", 32'(adc_peak), 100);
    feed(14'h3D44);
    feed(14'h0);
    chk("peak_hold", 32'(adc_peak), 100);
    feed(14'h0);
    chk("peak_300", 32'(adc_peak), 300);
    feed(14'h0);
    chk("peak_700", 32'(adc_peak), 700);

    cfg_write(32'h0003_0000);
    adc_or_in = 1'b1;
    repeat (4) feed(14'h1234);
    adc_or_in = 1'b0;
    chk("pre_rst_data", 32'(adc_data), 32'h1234);
    #2 adc_rst_n = 1'b0;
    #1;
    chk("async_rst_data", 32'(adc_data), 0);
    chk("async_rst_ovfl", 32'(adc_ovfl), 0);
    chk("async_rst_peak", 32'(adc_peak), 0);
    chk("async_rst_clip", 32'(clip_hold), 0);
    step();
    adc_rst_n = 1'b1;
    feed(14'h0111);
    chk("post_rst_c1", 32'(adc_data), 0);
    feed(14'h0222);
    chk("post_rst_c2", 32'(adc_data), 0);
    feed(14'h0333);
    chk("post_rst_c3", 32'(adc_data), 32'h0111);

`ifdef ADC_DC_BLOCK_EN
    adc_raw_in = 14'd1000;
    cfg_write(32'hA);
    feed(14'd1000);
    feed(14'd1000);
    chk("dc_first", 32'(adc_data), 1000);
    repeat (4093) feed(14'd1000);
    chk_rng("dc_decay_tau", int'($signed(adc_data)), 340, 400);
    repeat (26000) feed(14'd1000);
    chk_rng("dc_settled", int'($signed(adc_data)), -2, 2);

    adc_raw_in = 14'd1500;
    cfg_write(32'h6);
    repeat (3) feed(14'd1500);
    v0 = int'($signed(adc_data));
    chk_rng("freeze_level", v0, 500, 502);
    repeat (100) feed(14'd1500);
    chk("freeze_const", 32'(adc_data), 32'(v0));

    cfg_write(32'hE);
    repeat (3) feed(14'd1500);
    chk("clr_freeze_a", 32'(adc_data), 1500);
    repeat (50) feed(14'd1500);
    chk("clr_freeze_b", 32'(adc_data), 1500);

    adc_raw_in = 14'h3E0C;
    cfg_write(32'hA);
    repeat (32000) feed(14'h3E0C);
    chk("dc_neg_settled", 32'(adc_data), 0);
    chk("dc_neg_ovfl", 32'(adc_ovfl), 0);
    feed(14'h1F40);
    feed(14'h3E0C);
    feed(14'h3E0C);
    chk("sat_data", 32'(adc_data), 32'h1FFF);
    chk("sat_ovfl", 32'(adc_ovfl), 1);
    feed(14'h3E0C);
    chk("sat_ovfl_clear", 32'(adc_ovfl), 0);
`else
    adc_raw_in = 14'd1000;
    cfg_write(32'hA);
    repeat (5000) feed(14'd1000);
    chk("bypass_const", 32'(adc_data), 1000);
    adc_raw_in = 14'h1F40;
    cfg_write(32'hE);
    feed(14'h1F40);
    feed(14'h1F40);
    chk("bypass_8000", 32'(adc_data), 32'h1F40);
    chk("bypass_ovfl", 32'(adc_ovfl), 0);
    v0 = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
